// File: rtl/vx_mem_responder_pkg.sv
// rtl/vx_mem_responder_pkg.sv - shared types, widths and parameter limits for vx_mem_responder
package vx_mem_responder_pkg;

  // Default line/tag widths; the FIFO entry type defaults to these
  localparam int RSP_DATA_WIDTH = 512;
  localparam int RSP_TAG_WIDTH  = 8;

  // Legal LATENCY range
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 16;

  typedef struct packed {
    logic [RSP_DATA_WIDTH-1:0] data;
    logic [RSP_TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

  // One enable bit per data byte
  function automatic int byteen_width(input int data_width);
    return data_width / 8;
  endfunction

  // Credit counter must represent 0..depth inclusive
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vx_mem_rsp_fifo.sv
// rtl/vx_mem_rsp_fifo.sv - in-order read response FIFO whose head is valid the edge after a push into an empty queue
module vx_mem_rsp_fifo
  import vx_mem_responder_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = rsp_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  entry_t        buf_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // The head reads storage directly, so an entry pushed into an empty queue needs no
  // extra staging; empty forces zeros so the response bus is quiet in and after reset.
  assign head_o  = empty_o ? entry_t'('0) : buf_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, not reset
  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - byte-masked line memory with fixed-latency tagged read responses; MEM_RSP_PERF_EN adds perf counters
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = RSP_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = RSP_TAG_WIDTH,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int LATENCY        = 4,
  parameter int RSP_DEPTH      = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                mem_req_valid,
  input  logic                                mem_req_rw,
  input  logic [byteen_width(DATA_WIDTH)-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]               mem_req_addr,
  input  logic [DATA_WIDTH-1:0]               mem_req_data,
  input  logic [TAG_WIDTH-1:0]                mem_req_tag,
  output logic                                mem_req_ready,
  output logic                                mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]               mem_rsp_data,
  output logic [TAG_WIDTH-1:0]                mem_rsp_tag,
  input  logic                                mem_rsp_ready,
`ifdef MEM_RSP_PERF_EN
  output logic [31:0]                         perf_reads,
  output logic [31:0]                         perf_writes,
  output logic [31:0]                         perf_stalls,
`endif
  output logic                                busy
);

  localparam int BEW   = byteen_width(DATA_WIDTH);
  localparam int CW    = credit_width(RSP_DEPTH);
  localparam int LINES = 1 << MEM_LINES_LOG2;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("vx_mem_responder: LATENCY out of range");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vx_mem_responder: RSP_DEPTH must be a power of 2 and at least 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("vx_mem_responder: DATA_WIDTH must be a multiple of 8");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  logic                      ready_en_q;
  logic [CW-1:0]             credits_q, credits_d;
  logic                      rd_fire, wr_fire, rsp_fire;
  logic [MEM_LINES_LOG2-1:0] line;
  logic                      addr_hi_unused;
  logic [DATA_WIDTH-1:0]     mem_q [LINES];
  logic [LATENCY-1:0]        pipe_vld_q;
  entry_t                    pipe_ent_q [LATENCY];
  entry_t                    fifo_head;
  logic                      fifo_empty;
  logic                      fifo_full_unused;

  // Upper address bits alias onto the low lines
  assign line           = mem_req_addr[MEM_LINES_LOG2-1:0];
  assign addr_hi_unused = ^mem_req_addr[ADDR_WIDTH-1:MEM_LINES_LOG2];

  // Every read holds a credit from accept until its response fires, so the
  // pipeline plus FIFO can never hold more than RSP_DEPTH entries. Writes stall
  // too when credits run out so requests stay in order.
  assign mem_req_ready = ready_en_q && (credits_q < CW'(RSP_DEPTH));
  assign rd_fire       = mem_req_valid && mem_req_ready && !mem_req_rw;
  assign wr_fire       = mem_req_valid && mem_req_ready && mem_req_rw;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign mem_rsp_valid = !fifo_empty;
  assign mem_rsp_data  = fifo_head.data;
  assign mem_rsp_tag   = fifo_head.tag;
  assign busy          = (credits_q != '0);

  // Credit next-state: simultaneous accept and fire cancel out
  always_comb begin
    credits_d = credits_q;
    if (rd_fire && !rsp_fire)      credits_d = credits_q + 1'b1;
    else if (!rd_fire && rsp_fire) credits_d = credits_q - 1'b1;
  end

  // Credits and the ready enable that rises on the first edge out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q <= 1'b0;
      credits_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      credits_q  <= credits_d;
    end
  end

  // Byte-masked line storage; survives reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BEW; b++) begin
        if (mem_req_byteen[b]) mem_q[line][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  // Latency pipeline valid bits; reset drops every in-flight read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // Latency pipeline payload; storage is sampled on the accept edge
  always_ff @(posedge clk) begin
    pipe_ent_q[0] <= '{data: mem_q[line], tag: mem_req_tag};
    for (int i = 1; i < LATENCY; i++) pipe_ent_q[i] <= pipe_ent_q[i-1];
  end

  vx_mem_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (pipe_vld_q[LATENCY-1]),
    .push_data_i (pipe_ent_q[LATENCY-1]),
    .pop_i       (rsp_fire),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full_unused)
  );

`ifdef MEM_RSP_PERF_EN
  logic [31:0] perf_reads_q, perf_writes_q, perf_stalls_q;

  // Accepted reads, accepted writes and refused request cycles, wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (rd_fire) perf_reads_q <= perf_reads_q + 32'd1;
      if (wr_fire) perf_writes_q <= perf_writes_q + 32'd1;
      if (mem_req_valid && !mem_req_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb/tb_vx_mem_responder.sv - scoreboard bench for vx_mem_responder with a line-array reference model
module tb_vx_mem_responder;

  localparam int DW = 512, AW = 26, TW = 8, BW = DW / 8, LAT = 4, DEPTH = 8, LL2 = 10;

  logic          clk, reset_n;
  logic          mem_req_valid, mem_req_rw;
  logic [BW-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready, mem_rsp_valid, mem_rsp_ready, busy;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
`ifdef MEM_RSP_PERF_EN
  logic [31:0]   perf_reads, perf_writes, perf_stalls;
  int            exp_reads = 0, exp_writes = 0, exp_stalls = 0;
`endif

  vx_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .MEM_LINES_LOG2(LL2), .LATENCY(LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
`ifdef MEM_RSP_PERF_EN
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls),
`endif
    .busy(busy)
  );

  typedef struct { logic [DW-1:0] data; logic [TW-1:0] tag; } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [1 << LL2];
  int            errors = 0, checks = 0;
  int            cyc = 0, lat_cyc = 0;
  bit            lat_armed = 0, probe_next = 0;
  int            rdy_mode = 0;
  bit            rdy_const = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Response ready: 0 = constant, 1 = toggle every cycle, 2 = random
  initial begin
    mem_rsp_ready = 0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       mem_rsp_ready = ~mem_rsp_ready;
        2:       mem_rsp_ready = 1'($urandom);
        default: mem_rsp_ready = rdy_const;
      endcase
    end
  end

  // Monitor: pop expected entry on every response fire, check hold while stalled
  initial begin
    exp_t          e;
    bit            hold;
    logic [DW-1:0] hd;
    logic [TW-1:0] ht;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !mem_rsp_valid) begin
        hold = 0;
      end else begin
        if (lat_armed) begin
          check(cyc - lat_cyc == LAT, "rsp_latency", DW'(cyc - lat_cyc), DW'(LAT));
          lat_armed = 0;
        end
        if (hold) begin
          check(mem_rsp_data == hd, "hold_data", mem_rsp_data, hd);
          check(mem_rsp_tag == ht, "hold_tag", DW'(mem_rsp_tag), DW'(ht));
        end
        if (mem_rsp_ready) begin
          hold = 0;
          check(exp_q.size() != 0, "rsp_unexpected", DW'(mem_rsp_tag), DW'(exp_q.size()));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(mem_rsp_tag == e.tag, "rsp_tag", DW'(mem_rsp_tag), DW'(e.tag));
            check(mem_rsp_data == e.data, "rsp_data", mem_rsp_data, e.data);
          end
        end else begin
          hold = 1;
          hd   = mem_rsp_data;
          ht   = mem_rsp_tag;
        end
      end
    end
  end

  // Present one request until accepted or max_wait cycles pass; update the model on accept
  task automatic issue(input bit rw, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                       input logic [DW-1:0] data, input logic [TW-1:0] tag, input int max_wait,
                       output bit acc);
    logic [LL2-1:0] line;
    line           = addr[LL2-1:0];
    mem_req_valid  = 1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    mem_req_tag    = tag;
    acc = 0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      if (mem_req_ready) begin
        acc = 1;
        if (rw) begin
          for (int b = 0; b < BW; b++) if (be[b]) ref_mem[line][b*8 +: 8] = data[b*8 +: 8];
`ifdef MEM_RSP_PERF_EN
          exp_writes++;
`endif
        end else begin
          exp_q.push_back('{data: ref_mem[line], tag: tag});
`ifdef MEM_RSP_PERF_EN
          exp_reads++;
`endif
        end
      end else begin
`ifdef MEM_RSP_PERF_EN
        exp_stalls++;
`endif
      end
      @(posedge clk);
      #1;
      if (acc && !rw && probe_next) begin
        lat_cyc    = cyc;
        lat_armed  = 1;
        probe_next = 0;
      end
    end
    mem_req_valid = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    bit acc;
    issue(1'b1, a, be, d, '0, 50, acc);
    check(acc, "wr_accept", DW'(acc), DW'(1));
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
    bit acc;
    issue(1'b0, a, '0, '0, t, 50, acc);
    check(acc, "rd_accept", DW'(acc), DW'(1));
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0 && !busy, "drain", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            acc;
    int            n_acc, stale;
    logic [AW-1:0] a;
    logic [DW-1:0] a5;

    reset_n = 0; mem_req_valid = 0; mem_req_rw = 0; mem_req_byteen = '0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0;
    repeat (3) @(negedge clk);
    check(mem_req_ready == 0, "rst_req_ready", DW'(mem_req_ready), DW'(0));
    check(mem_rsp_valid == 0, "rst_rsp_valid", DW'(mem_rsp_valid), DW'(0));
    check(busy == 0, "rst_busy", DW'(busy), DW'(0));
    check(mem_rsp_data == '0, "rst_rsp_data", mem_rsp_data, '0);
    check(mem_rsp_tag == '0, "rst_rsp_tag", DW'(mem_rsp_tag), DW'(0));
    #1 reset_n = 1;
    #1 check(mem_req_ready == 0, "ready_before_edge", DW'(mem_req_ready), DW'(0));
    @(posedge clk);
    #1 check(mem_req_ready == 1, "ready_after_edge", DW'(mem_req_ready), DW'(1));
    rdy_const = 1;

    // Fill the working set of lines 0x10..0x1F
    for (int l = 16; l < 32; l++) wr(AW'(l), '1, rand_line());

    // Full write then immediate read, with latency probe
    a5 = {BW{8'hA5}};
    wr(26'h10, '1, a5);
    probe_next = 1;
    rd(26'h10, 8'h03);
    drain(100);

    // Byte-0-only write over the A5 line
    wr(26'h10, 64'h1, '1);
    rd(26'h10, 8'h04);
    drain(100);

    // Saturate credits with responses blocked
    rdy_const = 0;
    @(posedge clk);
    #1;
    n_acc = 0;
    for (int t = 0; t < 10; t++) begin
      issue(1'b0, AW'(16 + t), '0, '0, TW'(t), 3, acc);
      if (acc) n_acc++;
    end
    check(n_acc == 8, "sat_accepted", DW'(n_acc), DW'(8));
    check(mem_req_ready == 0, "sat_ready_low", DW'(mem_req_ready), DW'(0));
    rdy_const = 1;
    @(negedge clk);
    check(mem_req_ready == 0, "sat_ready_hold", DW'(mem_req_ready), DW'(0));
    @(posedge clk);
    #1 check(mem_req_ready == 1, "sat_ready_reassert", DW'(mem_req_ready), DW'(1));
    rd(AW'(24), 8'd8);
    rd(AW'(25), 8'd9);
    drain(200);

    // Back-to-back reads against a toggling response ready
    rdy_mode = 1;
    rd(26'h11, 8'd1);
    rd(26'h12, 8'd2);
    rd(26'h13, 8'd3);
    drain(200);

    // Random traffic with aliased addresses and random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 300; k++) begin
      a = AW'(16 + $urandom_range(0, 15)) | (AW'($urandom_range(0, 65535)) << LL2);
      case ($urandom_range(0, 3))
        0:       begin @(posedge clk); #1; end
        1:       wr(a, {$urandom, $urandom}, rand_line());
        default: rd(a, TW'($urandom));
      endcase
    end
    drain(3000);
    rdy_mode = 0;

    // Reset with reads in flight
    rdy_const = 0;
    @(posedge clk);
    #1;
    for (int t = 0; t < 5; t++) rd(AW'(16 + t), TW'(8'h40 + t));
    repeat (3) @(posedge clk);
    #1;
    check(busy == 1, "inflight_busy", DW'(busy), DW'(1));
    check(mem_rsp_valid == 1, "inflight_valid", DW'(mem_rsp_valid), DW'(1));
    #2 reset_n = 0;
    #1;
    check(mem_rsp_valid == 0, "midrst_valid", DW'(mem_rsp_valid), DW'(0));
    check(mem_req_ready == 0, "midrst_ready", DW'(mem_req_ready), DW'(0));
    check(busy == 0, "midrst_busy", DW'(busy), DW'(0));
    check(mem_rsp_tag == '0, "midrst_tag", DW'(mem_rsp_tag), DW'(0));
    exp_q.delete();
`ifdef MEM_RSP_PERF_EN
    exp_reads = 0; exp_writes = 0; exp_stalls = 0;
`endif
    repeat (2) @(negedge clk);
    #1 reset_n = 1;
    rdy_const = 1;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_rsp_valid) stale++;
    end
    check(stale == 0, "no_stale_rsp", DW'(stale), DW'(0));
    @(posedge clk);
    #1;
    for (int t = 0; t < 5; t++) rd(AW'(16 + t), TW'(8'h50 + t));
    drain(200);

    // Saturation again, then a refused read for two cycles and a few writes
    rdy_const = 0;
    @(posedge clk);
    #1;
    for (int t = 0; t < 8; t++) rd(AW'(20 + t), TW'(8'h60 + t));
    issue(1'b0, AW'(28), '0, '0, 8'h70, 2, acc);
    check(!acc, "refused_read", DW'(acc), DW'(0));
    rdy_const = 1;
    drain(200);
    wr(26'h1E, '1, rand_line());
    wr(26'h1F, {$urandom, $urandom}, rand_line());
    rd(26'h1E, 8'h71);
    drain(200);

`ifdef MEM_RSP_PERF_EN
    check(perf_reads == 32'(exp_reads), "perf_reads", DW'(perf_reads), DW'(exp_reads));
    check(perf_writes == 32'(exp_writes), "perf_writes", DW'(perf_writes), DW'(exp_writes));
    check(perf_stalls == 32'(exp_stalls), "perf_stalls", DW'(perf_stalls), DW'(exp_stalls));
`endif

    check(exp_q.size() == 0, "scoreboard_empty", DW'(exp_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
